// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// A runtime-loadable pattern of up to PAT_W bits is matched against the most
// recently accepted serial bits. Matches may overlap or restart the window.
// Outputs are a Mealy match (z), its registered copy (hit), and a saturating
// match counter with a saturation flag for the status block.
module seq_detector_param #(
  parameter int                PAT_W   = 4,
  parameter int                CNT_W   = 8,
  parameter logic [PAT_W-1:0]  RST_PAT = 4'b1011,
  parameter int                RST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inp,
  input  logic                         en,
  input  logic                         ovl,
  input  logic                         load,
  input  logic [PAT_W-1:0]             pat_in,
  input  logic [$clog2(PAT_W+1)-1:0]   len_in,
  input  logic                         clr,
  output logic                         z,
  output logic                         hit,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int                LEN_W    = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0]  FILL_MAX = LEN_W'(PAT_W - 1);
  localparam logic [LEN_W-1:0]  LEN_RST  = LEN_W'(RST_LEN);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  mask;
  logic [LEN_W:0]    fillPlusOne;
  logic              fillOk;
  logic              patOk;
  logic              zComb;

  // Build the compare window (history plus the live bit) and the length mask;
  // the live bit only counts once enough valid history bits exist.
  always_comb begin
    window      = {hist_q, inp};
    mask        = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    fillPlusOne = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    fillOk      = (fillPlusOne >= {1'b0, len_q});
    patOk       = (((window ^ pat_q) & mask) == '0);
    zComb       = rst_n & en & ~load & fillOk & patOk;
  end

  // Next-state logic: load restarts the detector, an enabled bit shifts the
  // history, and a non-overlapping match invalidates the history via fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    hit_d  = zComb;
    cnt_d  = cnt_q;
    if (load) begin
      pat_d  = pat_in;
      len_d  = ((len_in == '0) || (len_in > LEN_MAX)) ? LEN_MAX : len_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = window[PAT_W-2:0];
      if (zComb && !ovl) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
    if (clr) begin
      cnt_d = '0;
    end else if (zComb && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset to the default pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      len_q  <= LEN_RST;
      hit_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z         = zComb;
  assign hit       = hit_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule
